// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite widths, response encodings and RAM-slave FSM state types.
package axi4lite_pkg;
    localparam int AXI4LITE_ADDR_W = 32;
    localparam int AXI4LITE_DATA_W = 64;
    localparam int AXI4LITE_STRB_W = AXI4LITE_DATA_W / 8;
    typedef enum logic [1:0] {
        AXI4LITE_RESP_OKAY   = 2'b00,
        AXI4LITE_RESP_EXOKAY = 2'b01,
        AXI4LITE_RESP_SLVERR = 2'b10,
        AXI4LITE_RESP_DECERR = 2'b11
    } axi4lite_resp_e;
    typedef enum logic {R_IDLE, R_VALID} rd_state_e;
    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} wr_state_e;
endpackage

// File: rtl/axi4lite_if.sv
// axi4lite: 64-bit AXI4-Lite bus with master and slave modports.
interface axi4lite;
    import axi4lite_pkg::*;
    logic [AXI4LITE_ADDR_W-1:0] awaddr;
    logic                       awvalid;
    logic                       awready;
    logic [AXI4LITE_DATA_W-1:0] wdata;
    logic [AXI4LITE_STRB_W-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [AXI4LITE_ADDR_W-1:0] araddr;
    logic                       arvalid;
    logic                       arready;
    logic [AXI4LITE_DATA_W-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_ram_slave_bytemask_ram.sv
// bytemask_ram: single-clock RAM, byte-enabled write port and registered read-first read port.
module bytemask_ram import axi4lite_pkg::*; #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           waddr_i,
    input  logic [AXI4LITE_STRB_W-1:0] wstrb_i,
    input  logic [AXI4LITE_DATA_W-1:0] wdata_i,
    input  logic                       re_i,
    input  logic [IDX_W-1:0]           raddr_i,
    output logic [AXI4LITE_DATA_W-1:0] rdata_o
);
    logic [AXI4LITE_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < AXI4LITE_STRB_W; b++)
            if (we_i && wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/axi4lite_ram_slave.sv
// axi4lite_ram_slave: AXI4-Lite 64-bit RAM responder with independent read/write FSMs.
// Define AXI4LITE_RAM_SLAVE_RANGE_CHECK_EN to DECERR out-of-window accesses instead of wrapping.
module axi4lite_ram_slave import axi4lite_pkg::*; #(
    parameter logic [AXI4LITE_ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int DEPTH_WORDS = 1024
) (
    input logic    clk,
    input logic    rst,
    axi4lite.slave data_bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef AXI4LITE_RAM_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_depth_chk
        $error("axi4lite_ram_slave: DEPTH_WORDS must be a power of two");
    end

    // 33-bit offset so addresses below BASE_ADDR land out of range rather than wrapping in.
    function automatic logic in_range(input logic [AXI4LITE_ADDR_W-1:0] a);
        logic [AXI4LITE_ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (off >> 3) < (AXI4LITE_ADDR_W+1)'(DEPTH_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI4LITE_ADDR_W-1:0] a);
        logic [AXI4LITE_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+2:3];
    endfunction

    wr_state_e                  w_state_q, w_state_d;
    rd_state_e                  r_state_q, r_state_d;
    axi4lite_resp_e             bresp_q, bresp_d;
    logic                       aw_held_q, aw_held_d, w_held_q, w_held_d, r_err_q, r_err_d;
    logic [AXI4LITE_ADDR_W-1:0] awaddr_q;
    logic [AXI4LITE_DATA_W-1:0] wdata_q, ram_rdata;
    logic [AXI4LITE_STRB_W-1:0] wstrb_q;
    logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs, w_err, ram_we;

    assign data_bus.awready = !rst && (w_state_q == W_COLLECT) && !aw_held_q;
    assign data_bus.wready  = !rst && (w_state_q == W_COLLECT) && !w_held_q;
    assign data_bus.bvalid  = !rst && (w_state_q == W_RESP);
    assign data_bus.bresp   = bresp_q;
    assign data_bus.arready = !rst && (r_state_q == R_IDLE);
    assign data_bus.rvalid  = !rst && (r_state_q == R_VALID);
    assign data_bus.rresp   = r_err_q ? AXI4LITE_RESP_DECERR : AXI4LITE_RESP_OKAY;
    assign data_bus.rdata   = r_err_q ? '0 : ram_rdata;

    assign aw_hs = data_bus.awvalid && data_bus.awready;
    assign w_hs  = data_bus.wvalid && data_bus.wready;
    assign b_hs  = data_bus.bvalid && data_bus.bready;
    assign ar_hs = data_bus.arvalid && data_bus.arready;
    assign r_hs  = data_bus.rvalid && data_bus.rready;
    assign w_err = RANGE_CHECK && !in_range(awaddr_q);

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q || aw_hs;
        w_held_d  = w_held_q || w_hs;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_COLLECT: w_state_d = (aw_held_d && w_held_d) ? W_COMMIT : W_COLLECT;
            W_COMMIT: begin
                ram_we    = !rst && !w_err;
                bresp_d   = w_err ? AXI4LITE_RESP_DECERR : AXI4LITE_RESP_OKAY;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                w_state_d = b_hs ? W_COLLECT : W_RESP;
                aw_held_d = aw_held_q && !b_hs;
                w_held_d  = w_held_q && !b_hs;
            end
            default: w_state_d = W_COLLECT;
        endcase
        r_state_d = ar_hs ? R_VALID : (r_hs ? R_IDLE : r_state_q);
        r_err_d   = ar_hs ? (RANGE_CHECK && !in_range(data_bus.araddr)) : r_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_COLLECT;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            r_err_q   <= 1'b0;
            bresp_q   <= AXI4LITE_RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            r_err_q   <= r_err_d;
            bresp_q   <= bresp_d;
            if (aw_hs) awaddr_q <= data_bus.awaddr;
            if (w_hs) begin
                wdata_q <= data_bus.wdata;
                wstrb_q <= data_bus.wstrb;
            end
        end
    end

    bytemask_ram #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (word_idx(awaddr_q)),
        .wstrb_i (wstrb_q),
        .wdata_i (wdata_q),
        .re_i    (ar_hs),
        .raddr_i (word_idx(data_bus.araddr)),
        .rdata_o (ram_rdata)
    );
endmodule
